// File: rtl/pixel_scan_counter.sv
// Layer/x/y scan generator feeding the pipe-1 RAM fetch stage over valid/ready.
// Frame geometry is latched at frame start and held until the next latch.
module pixel_scan_counter #(
  parameter int X_WIDTH     = 11,
  parameter int Y_WIDTH     = 11,
  parameter int LAYER_WIDTH = 6
) (
  input  logic                   pipelineClk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [X_WIDTH-1:0]     cfgWidth,
  input  logic [Y_WIDTH-1:0]     cfgHeight,
  input  logic [LAYER_WIDTH:0]   cfgLayers,
  input  logic                   nextPixelPulse,
  input  logic                   outReady,
  output logic                   outValid,
  output logic [LAYER_WIDTH-1:0] layer,
  output logic [X_WIDTH-1:0]     x,
  output logic [Y_WIDTH-1:0]     y,
  output logic                   lastLayer,
  output logic                   frameStart,
  output logic                   frameEnd,
  output logic                   busy
);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  localparam logic [X_WIDTH-1:0]     X_ONE      = X_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]     Y_ONE      = Y_WIDTH'(1);
  localparam logic [LAYER_WIDTH-1:0] L_STEP     = LAYER_WIDTH'(1);
  localparam logic [LAYER_WIDTH:0]   L_ONE      = (LAYER_WIDTH+1)'(1);
  localparam logic [LAYER_WIDTH:0]   MAX_LAYERS = {1'b1, {LAYER_WIDTH{1'b0}}};

  state_t                 state_reg, state_next;
  logic [LAYER_WIDTH-1:0] layer_reg, layer_next;
  logic [X_WIDTH-1:0]     x_reg, x_next;
  logic [Y_WIDTH-1:0]     y_reg, y_next;
  logic [X_WIDTH-1:0]     act_w_reg, act_w_next;
  logic [Y_WIDTH-1:0]     act_h_reg, act_h_next;
  logic [LAYER_WIDTH:0]   act_l_reg, act_l_next;
  logic                   frame_end_reg, frame_end_next;

  logic [X_WIDTH-1:0]     cfg_w_norm;
  logic [Y_WIDTH-1:0]     cfg_h_norm;
  logic [LAYER_WIDTH:0]   cfg_l_norm;
  logic                   layer_last;
  logic                   x_last;
  logic                   y_last;
  logic                   latch_cfg;

  // Zero sizes mean one; layer count saturates at the counter's full range.
  always_comb begin
    cfg_w_norm = (cfgWidth == '0) ? X_ONE : cfgWidth;
    cfg_h_norm = (cfgHeight == '0) ? Y_ONE : cfgHeight;
    if (cfgLayers == '0) begin
      cfg_l_norm = L_ONE;
    end else if (cfgLayers > MAX_LAYERS) begin
      cfg_l_norm = MAX_LAYERS;
    end else begin
      cfg_l_norm = cfgLayers;
    end
  end

  assign layer_last = ({1'b0, layer_reg} == (act_l_reg - L_ONE));
  assign x_last     = (x_reg == (act_w_reg - X_ONE));
  assign y_last     = (y_reg == (act_h_reg - Y_ONE));

  always_comb begin
    state_next     = state_reg;
    layer_next     = layer_reg;
    x_next         = x_reg;
    y_next         = y_reg;
    act_w_next     = act_w_reg;
    act_h_next     = act_h_reg;
    act_l_next     = act_l_reg;
    frame_end_next = 1'b0;
    latch_cfg      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = SCAN;
          latch_cfg  = 1'b1;
        end
      end
      SCAN: begin
        // A forced skip behaves exactly like accepting the pixel's last layer,
        // so a simultaneous handshake cannot advance the pixel a second time.
        if (nextPixelPulse || outReady) begin
          if (nextPixelPulse || layer_last) begin
            layer_next = '0;
            if (x_last) begin
              x_next = '0;
              if (y_last) begin
                y_next         = '0;
                frame_end_next = 1'b1;
                if (continuous) begin
                  latch_cfg = 1'b1;
                end else begin
                  state_next = IDLE;
                end
              end else begin
                y_next = y_reg + Y_ONE;
              end
            end else begin
              x_next = x_reg + X_ONE;
            end
          end else begin
            layer_next = layer_reg + L_STEP;
          end
        end
      end
      default: state_next = IDLE;
    endcase

    if (latch_cfg) begin
      act_w_next = cfg_w_norm;
      act_h_next = cfg_h_norm;
      act_l_next = cfg_l_norm;
    end
  end

  always_ff @(posedge pipelineClk) begin
    if (!reset) begin
      state_reg     <= IDLE;
      layer_reg     <= '0;
      x_reg         <= '0;
      y_reg         <= '0;
      act_w_reg     <= X_ONE;
      act_h_reg     <= Y_ONE;
      act_l_reg     <= L_ONE;
      frame_end_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      layer_reg     <= layer_next;
      x_reg         <= x_next;
      y_reg         <= y_next;
      act_w_reg     <= act_w_next;
      act_h_reg     <= act_h_next;
      act_l_reg     <= act_l_next;
      frame_end_reg <= frame_end_next;
    end
  end

  assign outValid   = (state_reg == SCAN);
  assign busy       = (state_reg != IDLE);
  assign layer      = layer_reg;
  assign x          = x_reg;
  assign y          = y_reg;
  assign frameEnd   = frame_end_reg;
  assign lastLayer  = outValid && layer_last;
  assign frameStart = outValid && (layer_reg == '0) && (x_reg == '0) && (y_reg == '0);

endmodule

// File: tb/tb_pixel_scan_counter.sv
// Scoreboard bench for pixel_scan_counter: a frame-list model pushes expected
// beats; a negedge monitor retires them against the DUT outputs.
module tb_pixel_scan_counter;

  localparam int XW = 11;
  localparam int YW = 11;
  localparam int LW = 6;

  typedef struct {
    int l;
    int x;
    int y;
    int fid;
    bit fs;
    bit ll;
  } beat_t;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [XW-1:0] cfgWidth = '0;
  logic [YW-1:0] cfgHeight = '0;
  logic [LW:0]   cfgLayers = '0;
  logic          nextPixelPulse = 1'b0;
  logic          outReady = 1'b0;
  logic          outValid;
  logic [LW-1:0] layer;
  logic [XW-1:0] x;
  logic [YW-1:0] y;
  logic          lastLayer;
  logic          frameStart;
  logic          frameEnd;
  logic          busy;

  pixel_scan_counter #(.X_WIDTH(XW), .Y_WIDTH(YW), .LAYER_WIDTH(LW)) dut (
    .pipelineClk   (clk),
    .reset         (reset),
    .start         (start),
    .continuous    (continuous),
    .cfgWidth      (cfgWidth),
    .cfgHeight     (cfgHeight),
    .cfgLayers     (cfgLayers),
    .nextPixelPulse(nextPixelPulse),
    .outReady      (outReady),
    .outValid      (outValid),
    .layer         (layer),
    .x             (x),
    .y             (y),
    .lastLayer     (lastLayer),
    .frameStart    (frameStart),
    .frameEnd      (frameEnd),
    .busy          (busy)
  );

  initial forever #5 clk = ~clk;

  beat_t exp_q[$];
  int    errors = 0;
  int    checks = 0;
  int    fid_ctr = 0;
  int    frames_done = 0;
  int    retired = 0;
  bit    model_scan = 0;
  bit    mon_en = 0;
  bit    fe_exp = 0;
  bit    cont_exp = 0;

  function automatic int norm_size(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  function automatic int norm_layers(input int v);
    if (v == 0) return 1;
    if (v > (1 << LW)) return (1 << LW);
    return v;
  endfunction

  // Expected beat list of one whole frame, layer innermost.
  function automatic void push_frame(input int w, input int h, input int l);
    int nw = norm_size(w);
    int nh = norm_size(h);
    int nl = norm_layers(l);
    beat_t b;
    fid_ctr++;
    for (int yy = 0; yy < nh; yy++)
      for (int xx = 0; xx < nw; xx++)
        for (int li = 0; li < nl; li++) begin
          b.l = li; b.x = xx; b.y = yy; b.fid = fid_ctr;
          b.fs = (li == 0 && xx == 0 && yy == 0);
          b.ll = (li == nl - 1);
          exp_q.push_back(b);
        end
  endfunction

  // Monitor: every beat presented with a handshake or a forced skip retires one entry.
  initial begin
    beat_t e;
    bit    stall_prev = 0;
    logic [LW+XW+YW-1:0] prev_beat = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        checks++;
        if (frameEnd !== fe_exp) begin
          errors++;
          $display("FAIL frame_end: got %0b want %0b", frameEnd, fe_exp);
        end
        if (fe_exp) begin
          checks++;
          if (outValid !== cont_exp || busy !== cont_exp) begin
            errors++;
            $display("FAIL after_frame: valid=%0b busy=%0b want %0b", outValid, busy, cont_exp);
          end
        end
        fe_exp = 0;
        if (stall_prev) begin
          checks++;
          if (outValid !== 1'b1 || {layer, x, y} !== prev_beat) begin
            errors++;
            $display("FAIL stall_hold: valid=%0b beat=%h want 1 %h", outValid, {layer, x, y}, prev_beat);
          end
        end
        if (!reset) begin
          exp_q.delete();
          model_scan = 0;
          stall_prev = 0;
        end else begin
          if (outValid === 1'b1 && (outReady || nextPixelPulse)) begin
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL beat: unexpected l=%0d x=%0d y=%0d with nothing queued", layer, x, y);
            end else begin
              e = exp_q.pop_front();
              retired++;
              if ({layer, x, y, frameStart, lastLayer} !==
                  {LW'(e.l), XW'(e.x), YW'(e.y), e.fs, e.ll}) begin
                errors++;
                $display("FAIL beat: got l=%0d x=%0d y=%0d fs=%0b ll=%0b want l=%0d x=%0d y=%0d fs=%0b ll=%0b",
                         layer, x, y, frameStart, lastLayer, e.l, e.x, e.y, e.fs, e.ll);
              end
              if (nextPixelPulse)
                while (exp_q.size() > 0 && exp_q[0].fid == e.fid && exp_q[0].x == e.x && exp_q[0].y == e.y)
                  void'(exp_q.pop_front());
              if (exp_q.size() == 0 || exp_q[0].fid != e.fid) begin
                fe_exp   = 1;
                cont_exp = continuous;
                frames_done++;
                if (continuous) push_frame(int'(cfgWidth), int'(cfgHeight), int'(cfgLayers));
                else model_scan = 0;
              end
            end
          end
          stall_prev = (outValid === 1'b1) && !outReady && !nextPixelPulse;
          prev_beat  = {layer, x, y};
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if ({outValid, layer, x, y, frameEnd, busy, frameStart, lastLayer} !== '0) begin
      errors++;
      $display("FAIL %s: valid=%0b l=%0d x=%0d y=%0d fe=%0b busy=%0b want all 0",
               name, outValid, layer, x, y, frameEnd, busy);
    end
  endtask

  // ready_pct < 0 toggles outReady 1,0; tl >= 0 forces a skip on beat (tl,tx,ty);
  // cfg_mode 1 scrambles config every cycle, 2 sets width 3 on cycle 3.
  task automatic run(input int w, input int h, input int l, input int nframes,
                     input int ready_pct, input int pulse_pct, input int stray_pct,
                     input int cfg_mode, input int tl, input int tx, input int ty);
    int cyc = 0;
    int base = frames_done;
    cfgWidth   = XW'(w);
    cfgHeight  = YW'(h);
    cfgLayers  = (LW+1)'(l);
    continuous = (nframes > 1);
    start      = 1'b1;
    push_frame(w, h, l);
    model_scan = 1;
    @(posedge clk); #1;
    start = 1'b0;
    while (model_scan && cyc < 20000) begin
      if (ready_pct < 0) outReady = (cyc % 2 == 0);
      else outReady = ($urandom_range(99) < ready_pct);
      if (tl >= 0)
        nextPixelPulse = (exp_q.size() > 0 && exp_q[0].l == tl && exp_q[0].x == tx && exp_q[0].y == ty);
      else
        nextPixelPulse = (pulse_pct > 0) && ($urandom_range(99) < pulse_pct);
      start = !nextPixelPulse && (exp_q.size() >= 2) && ($urandom_range(99) < stray_pct);
      continuous = (frames_done - base) < (nframes - 1);
      if (cfg_mode == 1) begin
        cfgWidth  = XW'($urandom_range(5));
        cfgHeight = YW'($urandom_range(4));
        cfgLayers = (LW+1)'($urandom_range(6));
      end else if (cfg_mode == 2 && cyc == 3) begin
        cfgWidth = XW'(3);
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0; outReady = 0; nextPixelPulse = 0; continuous = 0;
    if (model_scan) begin
      checks++;
      errors++;
      $display("FAIL timeout: run w=%0d h=%0d l=%0d still scanning after %0d cycles", w, h, l, cyc);
      model_scan = 0;
      exp_q.delete();
    end
    $display("run w=%0d h=%0d l=%0d frames=%0d ready=%0d pulse=%0d -> %0d cycles",
             w, h, l, nframes, ready_pct, pulse_pct, cyc);
    @(posedge clk); #1;
  endtask

  initial begin
    int cyc;
    int base_r;
    int rw, rh, rl;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
    reset  = 1'b1;
    mon_en = 1;
    @(posedge clk); #1;

    nextPixelPulse = 1'b1;
    @(posedge clk); #1;
    nextPixelPulse = 1'b0;
    @(negedge clk);
    check_zero("idle_pulse");
    @(posedge clk); #1;

    run(4, 2, 3, 1, 100, 0, 0, 0, -1, 0, 0);
    run(4, 2, 3, 1, -1, 0, 0, 0, -1, 0, 0);
    run(4, 2, 3, 1, 100, 0, 0, 0, 1, 3, 0);
    run(2, 1, 1, 6, 100, 0, 0, 2, -1, 0, 0);
    run(0, 0, 0, 1, 100, 0, 0, 0, -1, 0, 0);
    run(2, 1, (1 << LW) + 5, 1, 100, 0, 0, 0, -1, 0, 0);

    // Reset while the eleventh beat is on the bus, then a clean restart.
    cfgWidth = 4; cfgHeight = 2; cfgLayers = 3;
    start = 1'b1;
    push_frame(4, 2, 3);
    model_scan = 1;
    base_r = retired;
    @(posedge clk); #1;
    start = 1'b0;
    outReady = 1'b1;
    cyc = 0;
    while (retired - base_r < 10 && cyc < 200) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (retired - base_r < 10) begin
      checks++;
      errors++;
      $display("FAIL timeout: only %0d beats before mid-frame reset", retired - base_r);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    outReady = 1'b0;
    @(negedge clk);
    check_zero("mid_reset");
    @(posedge clk); #1;
    run(4, 2, 3, 1, 70, 0, 0, 0, -1, 0, 0);

    for (int i = 0; i < 25; i++) begin
      rw = $urandom_range(5);
      rh = $urandom_range(4);
      rl = $urandom_range(6);
      if ($urandom_range(9) == 0) begin
        rw = 1; rh = 1; rl = 70;
      end
      run(rw, rh, rl, $urandom_range(1, 3), $urandom_range(30, 100),
          $urandom_range(15), 10, 1, -1, 0, 0);
    end

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
